// File: rtl/dut_model_pkg.sv
// Shared definitions for the behavioural adder DUT model.
//   state_t      : control FSM states (IDLE / RUN / DRAIN)
//   DEFAULT_LAT  : latency held in lat_q coming out of reset
//   lat_w()      : width needed to encode a latency of 0..max_lat
package dut_model_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEFAULT_LAT = 2;

  function automatic int lat_w(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/dut_delay_line.sv
// Fixed-depth shift register of {valid, data} stages.
//   clk_dut     : clock, rising edge
//   reset       : asynchronous, active-high; clears every stage
//   in_valid    : valid bit loaded into stage 1 every cycle
//   in_data     : data loaded into stage 1 every cycle
//   stage_valid : valid bit of every stage, bit k = stage k+1
//   stage_data  : data of every stage, stage k+1 at [k*WIDTH +: WIDTH]
//   any_valid   : OR of all stage valid bits
module dut_delay_line #(
  parameter int WIDTH   = 16,
  parameter int MAX_LAT = 8
) (
  input  logic                       clk_dut,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic [MAX_LAT-1:0]         stage_valid,
  output logic [MAX_LAT*WIDTH-1:0]   stage_data,
  output logic                       any_valid
);

  // NOTE: the data stages are reset along with the valid bits so that an
  // idle or freshly reset pipeline presents all-zero outputs.
  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      stage_valid <= '0;
      stage_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its
      // predecessor's old value, which is what makes this a shift register.
      stage_valid <= {stage_valid[MAX_LAT-2:0], in_valid};
      stage_data  <= {stage_data[(MAX_LAT-1)*WIDTH-1:0], in_data};
    end
  end

  assign any_valid = |stage_valid;

endmodule

// File: rtl/dut_adder_model.sv
// Adder DUT with run-time latency and deterministic fault injection.
//   clk_dut        : clock, rising edge
//   reset          : asynchronous, active-high
//   enable         : i_a/i_b pair valid this cycle
//   i_a, i_b       : operands
//   i_latency      : requested latency (0 -> 1, >MAX_LAT -> MAX_LAT)
//   i_fault_period : corrupt every Nth result, 0 = never
//   o_sum          : result, (a+b) mod 2^WIDTH, bit 0 flipped on a fault
//   o_valid        : o_sum carries a result
//   o_fault        : this result was deliberately corrupted
//   o_fault_ctr    : saturating count of injected faults
// Latency and fault period are captured only while IDLE, so a stream in
// flight always completes with the settings it started with.
module dut_adder_model
  import dut_model_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAX_LAT = 8,
  parameter int LAT_W   = lat_w(MAX_LAT)
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [LAT_W-1:0] i_latency,
  input  logic [15:0]      i_fault_period,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_valid,
  output logic             o_fault,
  output logic [31:0]      o_fault_ctr
);

  state_t                   state_q, state_d;
  logic [LAT_W-1:0]         lat_q, lat_clamped;
  logic [15:0]              period_q;
  logic [15:0]              fcnt_q;
  logic [MAX_LAT-1:0]       stage_valid;
  logic [MAX_LAT*WIDTH-1:0] stage_data;
  logic                     any_valid;
  logic                     tap_valid;
  logic [WIDTH-1:0]         tap_data;
  logic                     fault_hit;
  logic [WIDTH-1:0]         sum_in;

  // Carry out of the top bit is dropped by the equal-width assignment.
  assign sum_in = i_a + i_b;

  dut_delay_line #(
    .WIDTH   (WIDTH),
    .MAX_LAT (MAX_LAT)
  ) u_delay_line (
    .clk_dut     (clk_dut),
    .reset       (reset),
    .in_valid    (enable),
    .in_data     (sum_in),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .any_valid   (any_valid)
  );

  always_comb begin
    if (i_latency == '0)
      lat_clamped = LAT_W'(1);
    else if (i_latency > LAT_W'(MAX_LAT))
      lat_clamped = LAT_W'(MAX_LAT);
    else
      lat_clamped = i_latency;
  end

  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // DRAIN waits for the whole line to empty, not just the tapped stage,
  // so a later latency change never exposes a stale result.
  always_comb begin
    // NOTE: assigning a default before the case keeps this purely
    // combinational; a path that skipped state_d would infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)          state_d = ST_RUN;
        else if (!any_valid) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      lat_q    <= LAT_W'(DEFAULT_LAT);
      period_q <= '0;
    end else if (state_q == ST_IDLE) begin
      lat_q    <= lat_clamped;
      period_q <= i_fault_period;
    end
  end

  // Output tap: stage lat_q, unregistered.
  always_comb begin
    tap_valid = 1'b0;
    tap_data  = '0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (LAT_W'(k + 1) == lat_q) begin
        tap_valid = stage_valid[k];
        tap_data  = stage_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign fault_hit = tap_valid && (period_q != '0) && (fcnt_q == period_q - 16'd1);

  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      fcnt_q      <= '0;
      o_fault_ctr <= '0;
    end else if (fault_hit) begin
      fcnt_q <= '0;
      if (o_fault_ctr != 32'hFFFF_FFFF) o_fault_ctr <= o_fault_ctr + 32'd1;
    end else if (tap_valid) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign o_valid = tap_valid;
  assign o_fault = fault_hit;
  assign o_sum   = tap_data ^ {{(WIDTH-1){1'b0}}, fault_hit};

endmodule

// File: tb/tb_dut_adder_model.sv
// Self-checking bench for dut_adder_model. A transaction-level reference
// model predicts, for each accepted pair, the cycle its result appears and
// whether it is the Nth result to be corrupted.
module tb_dut_adder_model;

  localparam int WIDTH   = 16;
  localparam int MAX_LAT = 8;
  localparam int LAT_W   = 4;

  logic             clk_dut = 1'b0;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] i_a, i_b;
  logic [LAT_W-1:0] i_latency;
  logic [15:0]      i_fault_period;
  logic [WIDTH-1:0] o_sum;
  logic             o_valid, o_fault;
  logic [31:0]      o_fault_ctr;

  dut_adder_model #(.WIDTH(WIDTH), .MAX_LAT(MAX_LAT)) dut (
    .clk_dut        (clk_dut),
    .reset          (reset),
    .enable         (enable),
    .i_a            (i_a),
    .i_b            (i_b),
    .i_latency      (i_latency),
    .i_fault_period (i_fault_period),
    .o_sum          (o_sum),
    .o_valid        (o_valid),
    .o_fault        (o_fault),
    .o_fault_ctr    (o_fault_ctr)
  );

  always #5 clk_dut = ~clk_dut;

  // ---------------- reference model ----------------
  typedef struct {
    int               due;
    logic [WIDTH-1:0] sum;
  } pend_t;

  pend_t            pend_q[$];
  int               cyc;
  int               gap;       // enable-free edges since the last accepted pair
  int               eff_lat;
  int               eff_per;
  int               nvalid;    // results delivered since reset
  logic [31:0]      faults;
  logic             exp_v, exp_f;
  logic [WIDTH-1:0] exp_s;

  int vectors     = 0;
  int miscompares = 0;
  int seen_valid;

  function automatic int clamp_lat(input int l);
    if (l == 0) return 1;
    if (l > MAX_LAT) return MAX_LAT;
    return l;
  endfunction

  task automatic model_clear();
    pend_q.delete();
    gap     = 1000;
    eff_lat = 2;
    eff_per = 0;
    nvalid  = 0;
    faults  = '0;
  endtask

  // One clock: drive, advance the model at the edge, compute expectations
  // at the following falling edge.
  task automatic step(input logic en, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    pend_t p;
    enable = en;
    i_a    = a;
    i_b    = b;
    @(posedge clk_dut);
    cyc++;
    // The design is idle (and reloads its settings) once a whole line's
    // worth of empty edges plus the drain-to-idle edge have passed.
    if (gap >= MAX_LAT + 1) begin
      eff_lat = clamp_lat(int'(i_latency));
      eff_per = int'(i_fault_period);
    end
    if (en) begin
      p.due = cyc + eff_lat - 1;
      p.sum = WIDTH'((int'(a) + int'(b)) % 65536);
      pend_q.push_back(p);
      gap = 0;
    end else if (gap < 1000) begin
      gap++;
    end
    @(negedge clk_dut);
    exp_v = 1'b0;
    exp_f = 1'b0;
    exp_s = '0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      p = pend_q.pop_front();
      exp_v = 1'b1;
      nvalid++;
      if (eff_per != 0 && (nvalid % eff_per) == 0) begin
        exp_f  = 1'b1;
        faults = faults + 32'd1;
      end
      exp_s = exp_f ? (p.sum ^ 16'h0001) : p.sum;
    end
  endtask

  task automatic apply_reset();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk_dut);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    enable = 1'b0; i_a = '0; i_b = '0;
    i_latency = 4'd2; i_fault_period = '0;
    reset = 1'b1;
    model_clear();
    repeat (3) @(posedge clk_dut);
    @(negedge clk_dut);
    vectors++;
    if (o_valid !== 1'b0 || o_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got v=%b f=%b want v=0 f=0", o_valid, o_fault);
    end
    vectors++;
    if (o_sum !== '0) begin
      miscompares++;
      $display("FAIL reset_sum got %h want 0000", o_sum);
    end
    vectors++;
    if (o_fault_ctr !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_ctr got %0d want 0", o_fault_ctr);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    i_latency = 4'd2;
    seen_valid = 0;
    step(1'b1, 16'h0003, 16'h0004);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step(1'b0, '0, '0);
      else step(1'b0, 16'h1111, 16'h2222);
      if (o_valid === 1'b1) seen_valid++;
      vectors++;
      if (o_valid !== exp_v || o_fault !== exp_f || (exp_v && o_sum !== exp_s)) begin
        miscompares++;
        $display("FAIL basic cyc=%0d got v=%b f=%b sum=%h want v=%b f=%b sum=%h",
                 cyc, o_valid, o_fault, o_sum, exp_v, exp_f, exp_s);
      end
    end
    vectors++;
    if (seen_valid !== 1) begin
      miscompares++;
      $display("FAIL basic_count got %0d valid cycles want 1", seen_valid);
    end
  endtask

  task automatic test_wrap_stream();
    i_latency = 4'd5;
    seen_valid = 0;
    repeat (10) step(1'b0, '0, '0);
    for (int i = 0; i < 45; i++) begin
      if (i == 0)      step(1'b1, 16'hFFFF, 16'h0002);
      else if (i >= 12 && i < 32)
        step(1'b1, WIDTH'($urandom), WIDTH'($urandom));
      else             step(1'b0, '0, '0);
      if (i > 0 && o_valid === 1'b1 && exp_v) seen_valid++;
      vectors++;
      if (o_valid !== exp_v || o_fault !== exp_f || (exp_v && o_sum !== exp_s)) begin
        miscompares++;
        $display("FAIL wrap_stream cyc=%0d got v=%b f=%b sum=%h want v=%b f=%b sum=%h",
                 cyc, o_valid, o_fault, o_sum, exp_v, exp_f, exp_s);
      end
    end
    vectors++;
    if (seen_valid !== 21) begin
      miscompares++;
      $display("FAIL wrap_stream_count got %0d results want 21", seen_valid);
    end
  endtask

  task automatic test_clamp();
    logic [LAT_W-1:0] lats[2];
    lats[0] = 4'd0;
    lats[1] = 4'd15;
    foreach (lats[j]) begin
      i_latency = lats[j];
      for (int i = 0; i < 26; i++) begin
        if (i >= 10 && i < 14 && i != 12)
          step(1'b1, WIDTH'($urandom), WIDTH'($urandom));
        else
          step(1'b0, '0, '0);
        vectors++;
        if (o_valid !== exp_v || o_fault !== exp_f || (exp_v && o_sum !== exp_s)) begin
          miscompares++;
          $display("FAIL clamp lat_in=%0d cyc=%0d got v=%b f=%b sum=%h want v=%b f=%b sum=%h",
                   lats[j], cyc, o_valid, o_fault, o_sum, exp_v, exp_f, exp_s);
        end
      end
    end
  endtask

  task automatic test_mid_run_change();
    i_latency = 4'd3;
    repeat (10) step(1'b0, '0, '0);
    for (int i = 0; i < 34; i++) begin
      if (i == 3) i_latency = 4'd6;
      if (i < 10 || (i >= 24 && i < 29))
        step(1'b1, WIDTH'($urandom), WIDTH'($urandom));
      else
        step(1'b0, '0, '0);
      vectors++;
      if (o_valid !== exp_v || o_fault !== exp_f || (exp_v && o_sum !== exp_s)) begin
        miscompares++;
        $display("FAIL mid_run cyc=%0d got v=%b f=%b sum=%h want v=%b f=%b sum=%h",
                 cyc, o_valid, o_fault, o_sum, exp_v, exp_f, exp_s);
      end
    end
  endtask

  task automatic test_faults();
    apply_reset();
    i_latency = 4'd3;
    i_fault_period = 16'd4;
    release_reset();
    for (int i = 0; i < 20; i++) begin
      if (i < 12) step(1'b1, 16'h0010, 16'h0000);
      else        step(1'b0, '0, '0);
      vectors++;
      if (o_valid !== exp_v || o_fault !== exp_f || (exp_v && o_sum !== exp_s)) begin
        miscompares++;
        $display("FAIL fault_p4 cyc=%0d got v=%b f=%b sum=%h want v=%b f=%b sum=%h",
                 cyc, o_valid, o_fault, o_sum, exp_v, exp_f, exp_s);
      end
    end
    vectors++;
    if (o_fault_ctr !== 32'd3) begin
      miscompares++;
      $display("FAIL fault_p4_ctr got %0d want 3", o_fault_ctr);
    end
    apply_reset();
    i_fault_period = 16'd1;
    release_reset();
    for (int i = 0; i < 16; i++) begin
      if (i < 5 || i == 7) step(1'b1, WIDTH'($urandom), WIDTH'($urandom));
      else                 step(1'b0, '0, '0);
      vectors++;
      if (o_valid !== exp_v || o_fault !== exp_f || (exp_v && o_sum !== exp_s)) begin
        miscompares++;
        $display("FAIL fault_p1 cyc=%0d got v=%b f=%b sum=%h want v=%b f=%b sum=%h",
                 cyc, o_valid, o_fault, o_sum, exp_v, exp_f, exp_s);
      end
    end
    vectors++;
    if (o_fault_ctr !== faults || faults !== 32'd6) begin
      miscompares++;
      $display("FAIL fault_p1_ctr got %0d want 6", o_fault_ctr);
    end
    i_fault_period = 16'd0;
  endtask

  task automatic test_reset_midflight();
    i_latency = 4'd4;
    repeat (10) step(1'b0, '0, '0);
    repeat (3) step(1'b1, WIDTH'($urandom), WIDTH'($urandom));
    apply_reset();
    vectors++;
    if (o_valid !== 1'b0 || o_sum !== '0 || o_fault_ctr !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid got v=%b sum=%h ctr=%0d want v=0 sum=0000 ctr=0",
               o_valid, o_sum, o_fault_ctr);
    end
    i_latency = 4'd2;
    repeat (2) @(posedge clk_dut);
    release_reset();
    for (int i = 0; i < 14; i++) begin
      if (i == 8) step(1'b1, WIDTH'($urandom), WIDTH'($urandom));
      else        step(1'b0, '0, '0);
      vectors++;
      if (o_valid !== exp_v || o_fault !== exp_f || (exp_v && o_sum !== exp_s)) begin
        miscompares++;
        $display("FAIL reset_mid_after cyc=%0d got v=%b f=%b sum=%h want v=%b f=%b sum=%h",
                 cyc, o_valid, o_fault, o_sum, exp_v, exp_f, exp_s);
      end
    end
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) i_latency = LAT_W'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0)
        step(1'b1, WIDTH'($urandom), WIDTH'($urandom));
      else
        step(1'b0, WIDTH'($urandom), WIDTH'($urandom));
      vectors++;
      if (o_valid !== exp_v || o_fault !== exp_f || (exp_v && o_sum !== exp_s)) begin
        miscompares++;
        $display("FAIL random cyc=%0d got v=%b f=%b sum=%h want v=%b f=%b sum=%h",
                 cyc, o_valid, o_fault, o_sum, exp_v, exp_f, exp_s);
      end
    end
    for (int i = 0; i < 40; i++) begin
      if (i < 12) step(1'b0, '0, '0);
      else if (i % 5 == 0) step(1'b1, WIDTH'($urandom), WIDTH'($urandom));
      else step(1'b0, '0, '0);
      if (i == 11) i_latency = LAT_W'($urandom_range(0, 15));
      vectors++;
      if (o_valid !== exp_v || o_fault !== exp_f || (exp_v && o_sum !== exp_s)) begin
        miscompares++;
        $display("FAIL random_gapped cyc=%0d got v=%b f=%b sum=%h want v=%b f=%b sum=%h",
                 cyc, o_valid, o_fault, o_sum, exp_v, exp_f, exp_s);
      end
    end
    vectors++;
    if (o_fault_ctr !== faults) begin
      miscompares++;
      $display("FAIL random_ctr got %0d want %0d", o_fault_ctr, faults);
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_basic();
    test_wrap_stream();
    test_clamp();
    test_mid_run_change();
    test_faults();
    test_reset_midflight();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
